// File: rtl/rc4_pkg.sv
// Shared types and defaults for the RC4 key-search dispatcher and its arbiter.
package rc4_pkg;

  localparam int KEY_W_DEFAULT = 24;
  localparam logic [KEY_W_DEFAULT-1:0] KEY_MAX_DEFAULT = 24'h3FFFFF;

  typedef logic [KEY_W_DEFAULT-1:0] key_t;

  typedef enum logic [2:0] {
    IDLE,
    DISPATCH,
    DRAIN,
    FOUND,
    EXHAUSTED
  } dispatch_state_t;

endpackage

// File: rtl/key_dispatcher_arbiter.sv
// Round-robin arbiter: priority starts at the index after the last winner,
// and the pointer only moves when the caller actually consumes the grant.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;
  logic             hit;
  int               idx;
  int               winner;

  // Scan offsets from the pointer; comparing against constant indices keeps
  // every select static regardless of N.
  always_comb begin
    gnt    = '0;
    hit    = 1'b0;
    idx    = 0;
    winner = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N) idx = idx - N;
      for (int i = 0; i < N; i++) begin
        if (!hit && (i == idx) && req[i]) begin
          gnt[i] = 1'b1;
          hit    = 1'b1;
          winner = i;
        end
      end
    end
    ptr_d = ptr_q;
    if (hit) ptr_d = (winner + 1 >= N) ? '0 : PTR_W'(winner + 1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else if (advance) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/key_dispatcher.sv
// Hands RC4 key candidates to decrypt cores, tracks results and stops on success.
// Define KEY_DISPATCHER_STATS_EN to add the keys_tested counter output.
module key_dispatcher
  import rc4_pkg::*;
#(
  parameter int               CORES   = 4,
  parameter int               KEY_W   = KEY_W_DEFAULT,
  parameter logic [KEY_W-1:0] KEY_MAX = KEY_MAX_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CORES-1:0] key_req,
  output logic [CORES-1:0] key_gnt,
  output logic [KEY_W-1:0] key_out,
  input  logic [CORES-1:0] core_done,
  input  logic [CORES-1:0] core_found,
  output logic             abort,
  output logic             found,
  output logic             fail,
  output logic [KEY_W-1:0] found_key,
  output logic             busy
`ifdef KEY_DISPATCHER_STATS_EN
  ,
  output logic [KEY_W:0]   keys_tested
`endif
);

  dispatch_state_t  state_q;
  logic [CORES-1:0] outstanding_q;
  logic [CORES-1:0] keyGnt_q;
  logic [KEY_W-1:0] nextKey_q;
  logic [KEY_W-1:0] keyOut_q;
  logic [KEY_W-1:0] foundKey_q;
  logic [KEY_W-1:0] assigned_q [CORES];
  logic             abort_q;
  logic             found_q;
  logic             fail_q;
  logic             busy_q;

  logic [CORES-1:0] eligible;
  logic [CORES-1:0] arbGnt;
  logic [CORES-1:0] doneAcc;
  logic [CORES-1:0] successVec;
  logic [CORES-1:0] outstandingCleared;
  logic [KEY_W-1:0] winKey;
  logic             inSearch;
  logic             anySuccess;
  logic             issueGrant;

  // Success outranks both a same-cycle grant and the drain-complete exit;
  // scanning downwards leaves the lowest reporting core's key in winKey.
  always_comb begin
    inSearch           = (state_q == DISPATCH) || (state_q == DRAIN);
    eligible           = key_req & ~outstanding_q;
    doneAcc            = core_done & outstanding_q;
    successVec         = doneAcc & core_found;
    outstandingCleared = outstanding_q & ~doneAcc;
    anySuccess         = inSearch && (|successVec);
    issueGrant         = (state_q == DISPATCH) && (|eligible) && !anySuccess;
    winKey             = '0;
    for (int i = CORES - 1; i >= 0; i--) begin
      if (successVec[i]) winKey = assigned_q[i];
    end
  end

  rr_arbiter #(
    .N(CORES)
  ) u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    (eligible),
    .advance(issueGrant),
    .gnt    (arbGnt)
  );

`ifdef KEY_DISPATCHER_STATS_EN
  logic [KEY_W:0] keysTested_q;
  logic [KEY_W:0] doneCount;

  always_comb begin
    doneCount = '0;
    for (int i = 0; i < CORES; i++) begin
      doneCount = doneCount + (KEY_W + 1)'(doneAcc[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      keysTested_q <= '0;
    end else if ((state_q == IDLE || state_q == FOUND || state_q == EXHAUSTED) && start) begin
      keysTested_q <= '0;
    end else if (inSearch) begin
      keysTested_q <= keysTested_q + doneCount;
    end
  end

  assign keys_tested = keysTested_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      outstanding_q <= '0;
      keyGnt_q      <= '0;
      nextKey_q     <= '0;
      keyOut_q      <= '0;
      foundKey_q    <= '0;
      abort_q       <= 1'b0;
      found_q       <= 1'b0;
      fail_q        <= 1'b0;
      busy_q        <= 1'b0;
      for (int i = 0; i < CORES; i++) assigned_q[i] <= '0;
    end else begin
      keyGnt_q <= '0;
      case (state_q)
        IDLE, FOUND, EXHAUSTED: begin
          if (start) begin
            state_q       <= DISPATCH;
            nextKey_q     <= '0;
            outstanding_q <= '0;
            abort_q       <= 1'b0;
            found_q       <= 1'b0;
            fail_q        <= 1'b0;
            foundKey_q    <= '0;
            busy_q        <= 1'b1;
          end
        end
        DISPATCH, DRAIN: begin
          outstanding_q <= outstandingCleared;
          if (anySuccess) begin
            state_q    <= FOUND;
            found_q    <= 1'b1;
            abort_q    <= 1'b1;
            busy_q     <= 1'b0;
            foundKey_q <= winKey;
          end else if (issueGrant) begin
            keyGnt_q      <= arbGnt;
            keyOut_q      <= nextKey_q;
            outstanding_q <= outstandingCleared | arbGnt;
            for (int i = 0; i < CORES; i++) begin
              if (arbGnt[i]) assigned_q[i] <= nextKey_q;
            end
            // The last candidate parks the counter instead of wrapping.
            if (nextKey_q == KEY_MAX) begin
              state_q <= DRAIN;
            end else begin
              nextKey_q <= nextKey_q + 1'b1;
            end
          end else if ((state_q == DRAIN) && (outstandingCleared == '0)) begin
            state_q <= EXHAUSTED;
            fail_q  <= 1'b1;
            abort_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign key_gnt   = keyGnt_q;
  assign key_out   = keyOut_q;
  assign abort     = abort_q;
  assign found     = found_q;
  assign fail      = fail_q;
  assign found_key = foundKey_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_key_dispatcher.sv
// Scoreboard bench for key_dispatcher with CORES=4 and KEY_MAX=7.
module tb_key_dispatcher;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  key_req;
  logic [3:0]  key_gnt;
  logic [23:0] key_out;
  logic [3:0]  core_done;
  logic [3:0]  core_found;
  logic        abort;
  logic        found;
  logic        fail;
  logic [23:0] found_key;
  logic        busy;
`ifdef KEY_DISPATCHER_STATS_EN
  logic [24:0] keys_tested;
`endif

  typedef struct {
    logic [3:0]  gnt;
    logic [23:0] key;
  } grant_t;

  grant_t sb[$];
  int     testsRun;
  int     testsFailed;

  key_dispatcher #(
    .CORES  (4),
    .KEY_W  (24),
    .KEY_MAX(24'd7)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .key_req    (key_req),
    .key_gnt    (key_gnt),
    .key_out    (key_out),
    .core_done  (core_done),
    .core_found (core_found),
    .abort      (abort),
    .found      (found),
    .fail       (fail),
    .found_key  (found_key),
    .busy       (busy)
`ifdef KEY_DISPATCHER_STATS_EN
    ,
    .keys_tested(keys_tested)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] reqV, input logic [3:0] doneV,
                               input logic [3:0] foundV, input logic startV);
    key_req    = reqV;
    core_done  = doneV;
    core_found = foundV;
    start      = startV;
  endtask

  task automatic pushGrant(input logic [3:0] g, input logic [23:0] k);
    grant_t e;
    e.gnt = g;
    e.key = k;
    sb.push_back(e);
  endtask

  task automatic waitDrain(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    checkOutput(tag, sb.size(), 0);
    if (sb.size() != 0) sb.delete();
  endtask

  // Any grant pops the next expected (core, key); a grant with nothing queued is an error.
  always @(negedge clk) begin
    grant_t e;
    if (!reset && key_gnt !== 4'b0000) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected grant", {28'd0, key_gnt}, 32'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("grant core", {28'd0, key_gnt}, {28'd0, e.gnt});
        checkOutput("grant key", {8'd0, key_out}, {8'd0, e.key});
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    testsRun    = 0;
    testsFailed = 0;
    reset       = 1'b1;
    applyStimulus(4'h0, 4'h0, 4'h0, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    checkOutput("reset key_gnt", {28'd0, key_gnt}, 32'd0);
    checkOutput("reset key_out", {8'd0, key_out}, 32'd0);
    checkOutput("reset abort", {31'd0, abort}, 32'd0);
    checkOutput("reset found", {31'd0, found}, 32'd0);
    checkOutput("reset fail", {31'd0, fail}, 32'd0);
    checkOutput("reset found_key", {8'd0, found_key}, 32'd0);
    checkOutput("reset busy", {31'd0, busy}, 32'd0);

    // Grant order with all cores requesting from the start.
    for (int i = 0; i < 4; i++) pushGrant(4'b0001 << i, 24'(i));
    applyStimulus(4'hF, 4'h0, 4'h0, 1'b1);
    tick();
    applyStimulus(4'hF, 4'h0, 4'h0, 1'b0);
    checkOutput("busy in dispatch", {31'd0, busy}, 32'd1);
    waitDrain("order grants drained");
    repeat (4) tick();
    checkOutput("no grant once all outstanding", {28'd0, key_gnt}, 32'd0);

    // Core 2 succeeds on key 2.
    applyStimulus(4'hF, 4'b0100, 4'b0100, 1'b0);
    tick();
    applyStimulus(4'hF, 4'h0, 4'h0, 1'b0);
    checkOutput("success found", {31'd0, found}, 32'd1);
    checkOutput("success abort", {31'd0, abort}, 32'd1);
    checkOutput("success found_key", {8'd0, found_key}, 32'd2);
    checkOutput("success busy", {31'd0, busy}, 32'd0);
    checkOutput("success fail", {31'd0, fail}, 32'd0);
    repeat (3) tick();
    checkOutput("no grant in found", {28'd0, key_gnt}, 32'd0);

    // Restart, then cores 1 and 3 succeed together.
    for (int i = 0; i < 4; i++) pushGrant(4'b0001 << i, 24'(i));
    applyStimulus(4'hF, 4'h0, 4'h0, 1'b1);
    tick();
    applyStimulus(4'hF, 4'h0, 4'h0, 1'b0);
    checkOutput("restart clears found", {31'd0, found}, 32'd0);
    checkOutput("restart clears abort", {31'd0, abort}, 32'd0);
    checkOutput("restart clears found_key", {8'd0, found_key}, 32'd0);
    waitDrain("restart grants drained");
    applyStimulus(4'hF, 4'b1010, 4'b1010, 1'b0);
    tick();
    applyStimulus(4'hF, 4'h0, 4'h0, 1'b0);
    checkOutput("dual success found", {31'd0, found}, 32'd1);
    checkOutput("dual success lowest key", {8'd0, found_key}, 32'd1);

    // Exhaustion: two rounds of failures cover keys 0..7.
    for (int i = 0; i < 4; i++) pushGrant(4'b0001 << i, 24'(i));
    applyStimulus(4'hF, 4'h0, 4'h0, 1'b1);
    tick();
    applyStimulus(4'hF, 4'h0, 4'h0, 1'b0);
    waitDrain("exhaust round 1 drained");
    for (int i = 0; i < 4; i++) pushGrant(4'b0001 << i, 24'(i + 4));
    applyStimulus(4'hF, 4'hF, 4'h0, 1'b0);
    tick();
    applyStimulus(4'hF, 4'h0, 4'h0, 1'b0);
    waitDrain("exhaust round 2 drained");
    checkOutput("drain busy", {31'd0, busy}, 32'd1);
    checkOutput("drain not failed yet", {31'd0, fail}, 32'd0);
    applyStimulus(4'hF, 4'hF, 4'h0, 1'b0);
    tick();
    applyStimulus(4'hF, 4'h0, 4'h0, 1'b0);
    n = 0;
    while (fail !== 1'b1 && n < 4) begin
      tick();
      n++;
    end
    checkOutput("exhausted fail", {31'd0, fail}, 32'd1);
    checkOutput("exhausted found", {31'd0, found}, 32'd0);
    checkOutput("exhausted abort", {31'd0, abort}, 32'd1);
    checkOutput("exhausted busy", {31'd0, busy}, 32'd0);
`ifdef KEY_DISPATCHER_STATS_EN
    checkOutput("keys_tested at exhaustion", {7'd0, keys_tested}, 32'd8);
`endif
    repeat (3) tick();

    // Stray done, masked re-request, then reset mid-search.
    applyStimulus(4'h0, 4'h0, 4'h0, 1'b1);
    tick();
    applyStimulus(4'h0, 4'h0, 4'h0, 1'b0);
    checkOutput("restart clears fail", {31'd0, fail}, 32'd0);
    checkOutput("restart busy", {31'd0, busy}, 32'd1);
    applyStimulus(4'h0, 4'b0010, 4'b0010, 1'b0);
    tick();
    applyStimulus(4'h0, 4'h0, 4'h0, 1'b0);
    checkOutput("stray done ignored", {31'd0, found}, 32'd0);
    pushGrant(4'b0001, 24'd0);
    applyStimulus(4'b0001, 4'h0, 4'h0, 1'b0);
    waitDrain("single grant drained");
    repeat (3) tick();
    pushGrant(4'b0001, 24'd1);
    applyStimulus(4'b0001, 4'b0001, 4'h0, 1'b0);
    tick();
    applyStimulus(4'b0001, 4'h0, 4'h0, 1'b0);
    waitDrain("re-request after done drained");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    applyStimulus(4'h0, 4'h0, 4'h0, 1'b0);
    checkOutput("midreset key_gnt", {28'd0, key_gnt}, 32'd0);
    checkOutput("midreset key_out", {8'd0, key_out}, 32'd0);
    checkOutput("midreset busy", {31'd0, busy}, 32'd0);
    checkOutput("midreset abort", {31'd0, abort}, 32'd0);
`ifdef KEY_DISPATCHER_STATS_EN
    checkOutput("midreset keys_tested", {7'd0, keys_tested}, 32'd0);
`endif
    pushGrant(4'b0010, 24'd0);
    applyStimulus(4'b0010, 4'h0, 4'h0, 1'b1);
    tick();
    applyStimulus(4'b0010, 4'h0, 4'h0, 1'b0);
    waitDrain("post-reset key 0 drained");
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
